// File: rtl/nanorv32_tb_status.sv
// AHB-lite slave read by the simulation bench: sticky pass/fail status, console byte FIFO,
// free-running cycle counter and optional watchdog (enabled by NANORV32_TB_STATUS_WDT_EN).
module nanorv32_tb_status #(
    parameter int unsigned CONSOLE_DEPTH = 4,
    parameter logic [31:0] PASS_CODE     = 32'hCAFFE000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [3:0]  haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic        test_done,
    output logic        test_pass,
    output logic [31:0] test_code,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        wdt_timeout
);

    localparam int unsigned PTR_W = $clog2(CONSOLE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_CONSOLE = 2'd1,
        REG_CYCLE   = 2'd2,
        REG_WDT     = 2'd3
    } reg_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_STATUS,
        ST_WR_CON,
        ST_WR_WDT,
        ST_RD
    } state_e;

    state_e             state_q, state_d;
    reg_e               rd_sel_q, rd_sel_d;
    reg_e               addr_reg;
    logic               addr_accept;

    logic               done_q, pass_q;
    logic [31:0]        code_q;

    logic [7:0]         fifo_mem [CONSOLE_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               con_full, con_push, con_pop;

    logic [31:0]        cycle_q;
    logic [31:0]        wdt_count;
    logic               unused_addr_lsbs;

    assign unused_addr_lsbs = ^haddr[1:0];

    assign addr_accept = hsel & htrans[1] & hready;
    assign addr_reg    = reg_e'(haddr[3:2]);

    // Only a console write into a full FIFO stalls; everything else is zero-wait.
    assign con_full  = (count_q == CNT_W'(CONSOLE_DEPTH));
    assign hreadyout = !((state_q == ST_WR_CON) && con_full);
    assign hresp     = 1'b0;

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        rd_sel_d = rd_sel_q;
        if (hreadyout) begin
            state_d = ST_IDLE;
            if (addr_accept) begin
                if (hwrite) begin
                    case (addr_reg)
                        REG_STATUS:  state_d = ST_WR_STATUS;
                        REG_CONSOLE: state_d = ST_WR_CON;
                        REG_WDT:     state_d = ST_WR_WDT;
                        default:     state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d  = ST_RD;
                    rd_sel_d = addr_reg;
                end
            end
        end
    end

    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rd_sel_q <= REG_STATUS;
        end else begin
            state_q  <= state_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // STATUS captures only the first write after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            pass_q <= 1'b0;
            code_q <= '0;
        end else if ((state_q == ST_WR_STATUS) && !done_q) begin
            done_q <= 1'b1;
            pass_q <= (hwdata == PASS_CODE);
            code_q <= hwdata;
        end
    end

    assign test_done = done_q;
    assign test_pass = pass_q;
    assign test_code = code_q;

    assign con_push = (state_q == ST_WR_CON) && !con_full;
    assign con_pop  = con_valid & con_ready;

    always_comb begin
        count_d = count_q;
        if (con_push && !con_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (con_pop && !con_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: the byte array is not reset; count and pointers alone mark the live entries.
    always_ff @(posedge clk) begin
        if (con_push) begin
            fifo_mem[wr_ptr_q] <= hwdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (con_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (con_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign con_valid = (count_q != '0);
    assign con_data  = con_valid ? fifo_mem[rd_ptr_q] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

`ifdef NANORV32_TB_STATUS_WDT_EN
    logic        wdt_we;
    logic [31:0] wdt_cnt_q;
    logic        wdt_to_q;

    assign wdt_we = (state_q == ST_WR_WDT);

    // A reload landing on the expiry edge wins, so the timeout flag is left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_q <= '0;
            wdt_to_q  <= 1'b0;
        end else if (wdt_we) begin
            wdt_cnt_q <= hwdata;
        end else if (wdt_cnt_q != 32'd0) begin
            wdt_cnt_q <= wdt_cnt_q - 32'd1;
            if (wdt_cnt_q == 32'd1) begin
                wdt_to_q <= 1'b1;
            end
        end
    end

    assign wdt_count   = wdt_cnt_q;
    assign wdt_timeout = wdt_to_q;
`else
    assign wdt_count   = '0;
    assign wdt_timeout = 1'b0;
`endif

    always_comb begin
        hrdata = 32'h0;
        if (state_q == ST_RD) begin
            case (rd_sel_q)
                REG_STATUS:  hrdata = code_q;
                REG_CONSOLE: hrdata = 32'(count_q);
                REG_CYCLE:   hrdata = cycle_q;
                REG_WDT:     hrdata = wdt_count;
                default:     hrdata = 32'h0;
            endcase
        end
    end

endmodule
